// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one word-aligned request at a time to
// instruction memory, buffers responses in a 2-entry {pc, instr} FIFO for
// decode, and handles redirects by flushing the buffer and dropping the
// response of any request that was already in flight.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic [1:0]  count_q, count_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];

  logic        handshake;
  logic        pop;
  logic        push;
  logic        push_slot;
  logic        room;
  logic [1:0]  count_after;
  logic [31:0] redirect_pc;

  // Redirect beats everything: it suppresses both push and pop this cycle.
  assign redirect_pc = redirect_target & 32'hFFFF_FFFC;
  assign handshake   = (state_q == S_REQ) && imem_req_ready;
  assign pop         = (count_q != 2'd0) && inst_ready && !redirect_valid;
  assign push        = (state_q == S_WAIT) && imem_rsp_valid && !discard_q && !redirect_valid;

  // Occupancy after this cycle's flush/pop/push; the only request that can be
  // outstanding next cycle is the one a transition into REQ would create.
  assign count_after = redirect_valid ? 2'd0 : (count_q - {1'b0, pop} + {1'b0, push});
  assign room        = (count_after < 2'd2);

  // A push lands behind whatever survives this cycle's pop.
  assign push_slot   = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      discard_q <= 1'b0;
      count_q   <= 2'd0;
      // NOTE: the FIFO storage is reset because its head drives inst_data/inst_pc,
      // which must read as zero while in reset; larger memories would not be.
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed in the combinational blocks, independent of statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
    end
  end

  // Next-state logic: a new request is started only with fetch enabled and room.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (en && room) state_d = S_REQ;
      S_REQ:  if (handshake) state_d = S_WAIT;
      S_WAIT: if (imem_rsp_valid) state_d = (en && room) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: PC advance, discard tracking and FIFO shift/push/flush.
  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    count_d   = count_after;
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];

    if (handshake) req_pc_d = pc_q;

    // Any response retires the outstanding request, dropped or not.
    if ((state_q == S_WAIT) && imem_rsp_valid) discard_d = 1'b0;

    if (pop) fifo_d[0] = fifo_q[1];

    if (push) begin
      fifo_d[push_slot] = '{pc: req_pc_q, instr: imem_rsp_data};
      pc_d              = req_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      pc_d = redirect_pc;
      // A request left in flight by this redirect must have its response dropped;
      // a response arriving this very cycle is dropped directly instead.
      if (handshake || ((state_q == S_WAIT) && !imem_rsp_valid)) discard_d = 1'b1;
    end
  end

  // Outputs: request signals follow state/pc, decode sees the FIFO head.
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;
    inst_valid     = (count_q != 2'd0);
    inst_data      = fifo_q[0].instr;
    inst_pc        = fifo_q[0].pc;
  end

endmodule
